// File: rtl/hams_pkg.sv
// Shared types and constants for the hams merge-sort blocks.
//   pair            : sorter element; .info is the sort key, .data is payload
//   NUM_ELEMENTS    : total sorter capacity (all columns together)
//   MS_NUM_COLS     : number of sorter input columns
//   ms_ctrl_state_e : merge controller states
//   count_ones      : population count of a column bit-vector
package hams_pkg;

  localparam int NUM_ELEMENTS = 1024;
  localparam int KEY_W        = 16;
  localparam int VAL_W        = 16;
  localparam int MS_NUM_COLS  = 4;

  typedef struct packed {
    logic [KEY_W-1:0] info;
    logic [VAL_W-1:0] data;
  } pair;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MERGE = 2'd2,
    DONE  = 2'd3
  } ms_ctrl_state_e;

  function automatic logic [2:0] count_ones(input logic [MS_NUM_COLS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < MS_NUM_COLS; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/hams_col_order_chk.sv
// Per-column ordering monitor. Remembers the last accepted key of one column
// and flags any accepted key that is not strictly greater than it.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : forget history (start of a new job)
//   acc        : an element of this column is accepted this cycle
//   key        : key of that element
//   violation  : combinational; acc with key <= previous key of this column
module hams_col_order_chk
  import hams_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             acc,
  input  logic [KEY_W-1:0] key,
  output logic             violation
);

  logic             seen_reg;
  logic [KEY_W-1:0] prev_key_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_reg     <= 1'b0;
      prev_key_reg <= '0;
    end else if (clr) begin
      seen_reg     <= 1'b0;
      prev_key_reg <= '0;
    end else if (acc) begin
      seen_reg     <= 1'b1;
      prev_key_reg <= key;
    end
  end

  // Equal keys count as a violation: the sorter comparator cannot break a tie.
  assign violation = acc & seen_reg & (key <= prev_key_reg);

endmodule

// File: rtl/hams_merge_sort_ctrl.sv
// Job sequencer for hams_4to1_merge_sort.
// Loads up to four pre-sorted columns into the sorter, keeps the merge disabled
// until every active column has delivered its last element, then drains the
// merged stream to a valid/ready consumer.
//   start/col_mask                 : job request (sampled in IDLE)
//   in_vld/in_data/in_last/in_rdy  : per-column load stream, common ready
//   out_vld/out_data/out_last/out_rdy : merged output stream
//   ms_*                           : sorter interface (show-ahead read side)
//   busy/done/err_order/err_stall/elem_cnt : status
module hams_merge_sort_ctrl
  import hams_pkg::*;
#(
  parameter int FIFO_DEPTH   = NUM_ELEMENTS,
  parameter int STALL_CYCLES = 64,
  parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [MS_NUM_COLS-1:0]       col_mask,
  input  logic [MS_NUM_COLS-1:0]       in_vld,
  input  pair  [MS_NUM_COLS-1:0]       in_data,
  input  logic [MS_NUM_COLS-1:0]       in_last,
  output logic                         in_rdy,
  output logic                         out_vld,
  output pair                          out_data,
  output logic                         out_last,
  input  logic                         out_rdy,
  output logic [MS_NUM_COLS-1:0]       ms_col_ena,
  output logic [MS_NUM_COLS-1:0]       ms_col_vld,
  output pair  [MS_NUM_COLS-1:0]       ms_col_data,
  output logic                         ms_fifo_pop,
  input  logic                         ms_fifo_full,
  input  logic                         ms_fifo_empty,
  input  pair                          ms_sort_data,
  output logic                         busy,
  output logic                         done,
  output logic                         err_order,
  output logic                         err_stall,
  output logic [CNT_W-1:0]             elem_cnt
);

  localparam int              STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ms_ctrl_state_e         state_reg, state_next;
  logic [MS_NUM_COLS-1:0] act_reg, act_next;
  logic [MS_NUM_COLS-1:0] pend_last_reg, pend_last_next;
  logic [CNT_W-1:0]       push_cnt_reg, push_cnt_next;
  logic [CNT_W-1:0]       pop_cnt_reg, pop_cnt_next;
  logic [STALL_W-1:0]     stall_cnt_reg, stall_cnt_next;
  logic                   err_order_reg, err_order_next;
  logic                   err_stall_reg, err_stall_next;

  logic [MS_NUM_COLS-1:0] col_acc;
  logic [MS_NUM_COLS-1:0] col_viol;
  logic                   job_clr;
  logic [CNT_W:0]         push_sum;

  assign in_rdy      = (state_reg == LOAD) & ~ms_fifo_full;
  assign col_acc     = in_vld & act_reg & {MS_NUM_COLS{in_rdy}};
  assign job_clr     = (state_reg == IDLE) & start;
  assign out_vld     = (state_reg == MERGE) & ~ms_fifo_empty;
  assign out_data    = out_vld ? ms_sort_data : '0;
  assign ms_fifo_pop = out_vld & out_rdy;
  // push_cnt is at least 1 in MERGE: every active column sent a last element.
  assign out_last    = out_vld & (pop_cnt_reg == push_cnt_reg - CNT_W'(1));
  assign push_sum    = {1'b0, push_cnt_reg} + (CNT_W + 1)'(count_ones(col_acc));

  assign busy      = (state_reg != IDLE);
  assign err_order = err_order_reg;
  assign err_stall = err_stall_reg;
  assign elem_cnt  = push_cnt_reg;

  for (genvar gi = 0; gi < MS_NUM_COLS; gi++) begin : g_col
    assign ms_col_vld[gi]  = col_acc[gi];
    assign ms_col_data[gi] = (state_reg == LOAD) ? in_data[gi] : '0;

    hams_col_order_chk u_order_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (job_clr),
      .acc       (col_acc[gi]),
      .key       (in_data[gi].info),
      .violation (col_viol[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      act_reg       <= '0;
      pend_last_reg <= '0;
      push_cnt_reg  <= '0;
      pop_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
      err_order_reg <= 1'b0;
      err_stall_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      act_reg       <= act_next;
      pend_last_reg <= pend_last_next;
      push_cnt_reg  <= push_cnt_next;
      pop_cnt_reg   <= pop_cnt_next;
      stall_cnt_reg <= stall_cnt_next;
      err_order_reg <= err_order_next;
      err_stall_reg <= err_stall_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    act_next       = act_reg;
    pend_last_next = pend_last_reg;
    push_cnt_next  = push_cnt_reg;
    pop_cnt_next   = pop_cnt_reg;
    stall_cnt_next = stall_cnt_reg;
    err_order_next = err_order_reg;
    err_stall_next = err_stall_reg;
    ms_col_ena     = '0;
    done           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          act_next       = col_mask;
          pend_last_next = col_mask;
          push_cnt_next  = '0;
          pop_cnt_next   = '0;
          stall_cnt_next = '0;
          state_next     = (col_mask == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        push_cnt_next  = (push_sum > {1'b0, CNT_MAX}) ? CNT_MAX : push_sum[CNT_W-1:0];
        pend_last_next = pend_last_reg & ~(col_acc & in_last);
        if (col_viol != '0) err_order_next = 1'b1;
        // Merge only once no active column can still deliver a smaller head.
        if (pend_last_next == '0) state_next = MERGE;
      end
      MERGE: begin
        ms_col_ena = act_reg;
        if (ms_fifo_pop) begin
          if (pop_cnt_reg != CNT_MAX) pop_cnt_next = pop_cnt_reg + CNT_W'(1);
          stall_cnt_next = '0;
          if (out_last) state_next = DONE;
        end else if (out_vld) begin
          // Consumer backpressure: the sorter is making progress.
          stall_cnt_next = '0;
        end else begin
          stall_cnt_next = stall_cnt_reg + STALL_W'(1);
          if (stall_cnt_reg >= STALL_W'(STALL_CYCLES - 1)) begin
            err_stall_next = 1'b1;
            state_next     = DONE;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hams_merge_sort_ctrl.sv
`timescale 1ns/1ps
module tb_hams_merge_sort_ctrl;
  import hams_pkg::*;

  localparam int CNT_W = $clog2(NUM_ELEMENTS) + 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [3:0]             col_mask = '0;
  logic [3:0]             in_vld = '0;
  pair  [3:0]             in_data = '0;
  logic [3:0]             in_last = '0;
  logic                   in_rdy;
  logic                   out_vld;
  pair                    out_data;
  logic                   out_last;
  logic                   out_rdy = 1'b1;
  logic [3:0]             ms_col_ena;
  logic [3:0]             ms_col_vld;
  pair  [3:0]             ms_col_data;
  logic                   ms_fifo_pop;
  logic                   ms_fifo_full;
  logic                   ms_fifo_empty;
  pair                    ms_sort_data;
  logic                   busy, done, err_order, err_stall;
  logic [CNT_W-1:0]       elem_cnt;

  always #5 clk = ~clk;

  hams_merge_sort_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .col_mask(col_mask),
    .in_vld(in_vld), .in_data(in_data), .in_last(in_last), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_data(out_data), .out_last(out_last), .out_rdy(out_rdy),
    .ms_col_ena(ms_col_ena), .ms_col_vld(ms_col_vld), .ms_col_data(ms_col_data),
    .ms_fifo_pop(ms_fifo_pop), .ms_fifo_full(ms_fifo_full), .ms_fifo_empty(ms_fifo_empty),
    .ms_sort_data(ms_sort_data), .busy(busy), .done(done), .err_order(err_order),
    .err_stall(err_stall), .elem_cnt(elem_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // ---------------- behavioural sorter: per-column FIFOs, min-head merge
  pair        colq [4][$];
  logic [3:0] push_v = '0;
  pair        push_d [4];
  logic       pop_v = 1'b0;
  logic       m_empty = 1'b1;
  logic       m_full = 1'b0;
  pair        m_head = '0;
  int         m_head_col = 0;

  function automatic int head_col();
    int bc = -1;
    for (int i = 0; i < 4; i++)
      if (colq[i].size() > 0 && (bc < 0 || colq[i][0].info < colq[bc][0].info)) bc = i;
    return bc;
  endfunction

  // Equal heads jam the real comparator, so the model presents no data then.
  function automatic logic model_empty();
    logic dl = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (colq[i].size() > 0 && colq[j].size() > 0 && colq[i][0].info == colq[j][0].info)
          dl = 1'b1;
    return (head_col() < 0) || dl;
  endfunction

  function automatic pair model_head();
    int bc = head_col();
    return (bc < 0) ? pair'('0) : colq[bc][0];
  endfunction

  function automatic logic model_full();
    int tot = 0;
    for (int i = 0; i < 4; i++) tot += colq[i].size();
    return tot >= NUM_ELEMENTS;
  endfunction

  always @(negedge clk) begin
    push_v <= ms_col_vld;
    for (int i = 0; i < 4; i++) push_d[i] <= ms_col_data[i];
    pop_v <= ms_fifo_pop;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) colq[i].delete();
    end else begin
      if (pop_v && !m_empty) void'(colq[m_head_col].pop_front());
      for (int i = 0; i < 4; i++) if (push_v[i]) colq[i].push_back(push_d[i]);
    end
    m_empty    <= model_empty();
    m_full     <= model_full();
    m_head     <= model_head();
    m_head_col <= (head_col() < 0) ? 0 : head_col();
  end

  assign ms_fifo_empty = m_empty | (ms_col_ena == 4'b0);
  assign ms_fifo_full  = m_full;
  assign ms_sort_data  = m_head;

  // ---------------- scoreboard
  typedef struct {
    logic [15:0] key;
    logic        last;
  } exp_t;
  exp_t exp_q[$];
  int   n_pops = 0;
  int   last_cyc = -1;

  task automatic push_exp(input logic [15:0] key, input logic last);
    exp_t e;
    e.key  = key;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic score_one();
    exp_t e;
    if (rst_n && out_vld && out_rdy) begin
      n_pops++;
      if (out_last) last_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got key=%0d expected=none", out_data.info);
      end else begin
        e = exp_q.pop_front();
        $display("pop key=%0d last=%0b exp_key=%0d exp_last=%0b", out_data.info, out_last, e.key, e.last);
        check("out_key", 32'(out_data.info), 32'(e.key));
        check("out_payload", 32'(out_data.data), 32'(e.key ^ 16'hA5A5));
        check("out_last", 32'(out_last), 32'(e.last));
      end
    end
  endtask

  always @(negedge clk) score_one();

  // ---------------- stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] m);
    col_mask = m;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    col_mask = '0;
  endtask

  task automatic load_cycle(input logic [3:0] m, input logic [3:0] v, input logic [3:0] l,
                            input logic [15:0] k0, input logic [15:0] k1,
                            input logic [15:0] k2, input logic [15:0] k3);
    logic [15:0] k [4];
    k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
    for (int i = 0; i < 4; i++) begin
      in_data[i].info = k[i];
      in_data[i].data = k[i] ^ 16'hA5A5;
    end
    in_vld  = v;
    in_last = l;
    #1;
    check("in_rdy_load", 32'(in_rdy), 32'd1);
    check("ms_col_vld", 32'(ms_col_vld), 32'(v & m));
    tick();
    in_vld  = '0;
    in_last = '0;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        dcyc = cyc;
        break;
      end
      tick();
    end
    checks++;
    if (dcyc < 0) begin
      failures++;
      $display("FAIL wait_done: got=timeout expected=done within %0d cycles", budget);
    end else begin
      tick();
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_after_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int dcyc;
    int mcyc;
    int bad;
    int base;
    pair held;

    // reset state
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_in_rdy", 32'(in_rdy), 32'd0);
    check("rst_ena", 32'(ms_col_ena), 32'd0);
    check("rst_errs", 32'({err_order, err_stall}), 32'd0);
    check("rst_elem_cnt", 32'(elem_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // empty mask goes straight to DONE
    do_start(4'b0000);
    check("mask0_done", 32'(done), 32'd1);
    check("mask0_cnt", 32'(elem_cnt), 32'd0);
    tick();
    check("mask0_done_clear", 32'(done), 32'd0);

    // four-column merge
    for (int k = 1; k <= 7; k++) push_exp(16'(k), 1'b0);
    push_exp(16'd9, 1'b0);
    push_exp(16'd11, 1'b0);
    push_exp(16'd12, 1'b1);
    do_start(4'b1111);
    check("load_busy", 32'(busy), 32'd1);
    load_cycle(4'b1111, 4'b1111, 4'b1000, 16'd1, 16'd2, 16'd3, 16'd4);
    load_cycle(4'b1111, 4'b0111, 4'b0010, 16'd5, 16'd6, 16'd7, 16'd0);
    load_cycle(4'b1111, 4'b0101, 4'b0001, 16'd9, 16'd0, 16'd11, 16'd0);
    load_cycle(4'b1111, 4'b0100, 4'b0100, 16'd0, 16'd0, 16'd12, 16'd0);
    wait_done(100, dcyc);
    check("t1_done_after_last", 32'(dcyc - last_cyc), 32'd1);
    check("t1_elem_cnt", 32'(elem_cnt), 32'd10);
    check("t1_errs", 32'({err_order, err_stall}), 32'd0);

    // sparse mask, junk on inactive columns
    push_exp(16'd10, 1'b0);
    push_exp(16'd20, 1'b0);
    push_exp(16'd30, 1'b1);
    do_start(4'b0101);
    load_cycle(4'b0101, 4'b1111, 4'b0100, 16'd10, 16'd99, 16'd20, 16'd98);
    load_cycle(4'b0101, 4'b1001, 4'b1001, 16'd30, 16'd0, 16'd0, 16'd97);
    wait_done(100, dcyc);
    check("t2_elem_cnt", 32'(elem_cnt), 32'd3);

    // late last on column 1 holds the merge off
    push_exp(16'd1, 1'b0);
    push_exp(16'd2, 1'b0);
    push_exp(16'd3, 1'b0);
    push_exp(16'd4, 1'b1);
    do_start(4'b1111);
    load_cycle(4'b1111, 4'b1101, 4'b1101, 16'd1, 16'd0, 16'd3, 16'd4);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (ms_col_ena != 4'b0 || !busy) bad++;
      tick();
    end
    check("t3_ena_held_low", 32'(bad), 32'd0);
    check("t3_ena_before_last", 32'(ms_col_ena), 32'd0);
    load_cycle(4'b1111, 4'b0010, 4'b0010, 16'd0, 16'd2, 16'd0, 16'd0);
    check("t3_ena_after_last", 32'(ms_col_ena), 32'hF);
    wait_done(100, dcyc);

    // long consumer backpressure is not a stall
    for (int k = 1; k <= 6; k++) push_exp(16'(k), k == 6);
    do_start(4'b0011);
    load_cycle(4'b0011, 4'b0011, 4'b0000, 16'd1, 16'd2, 16'd0, 16'd0);
    load_cycle(4'b0011, 4'b0011, 4'b0000, 16'd3, 16'd4, 16'd0, 16'd0);
    load_cycle(4'b0011, 4'b0011, 4'b0011, 16'd5, 16'd6, 16'd0, 16'd0);
    base = n_pops;
    for (int i = 0; i < 50 && n_pops < base + 2; i++) tick();
    out_rdy = 1'b0;
    #1;
    held = out_data;
    check("t4_vld_at_hold", 32'(out_vld), 32'd1);
    for (int i = 0; i < 200; i++) tick();
    check("t4_vld_held", 32'(out_vld), 32'd1);
    check("t4_data_stable", 32'(out_data.info), 32'(held.info));
    check("t4_no_stall", 32'(err_stall), 32'd0);
    out_rdy = 1'b1;
    wait_done(100, dcyc);
    check("t4_elem_cnt", 32'(elem_cnt), 32'd6);

    // equal keys: order error, sorter jams, stall timeout
    do_start(4'b0011);
    load_cycle(4'b0011, 4'b0011, 4'b0010, 16'd5, 16'd5, 16'd0, 16'd0);
    check("t5_no_err_across_cols", 32'(err_order), 32'd0);
    load_cycle(4'b0011, 4'b0001, 4'b0001, 16'd5, 16'd0, 16'd0, 16'd0);
    mcyc = cyc;
    check("t5_err_order", 32'(err_order), 32'd1);
    check("t5_no_stall_yet", 32'(err_stall), 32'd0);
    wait_done(200, dcyc);
    check("t5_stall_cycles", 32'(dcyc - mcyc), 32'd64);
    check("t5_err_stall", 32'(err_stall), 32'd1);
    tick();
    tick();
    check("t5_errs_sticky", 32'({err_order, err_stall}), 32'b11);
    do_reset();
    check("t5_errs_cleared", 32'({err_order, err_stall}), 32'd0);

    // asynchronous reset in the middle of MERGE
    out_rdy = 1'b0;
    do_start(4'b0011);
    load_cycle(4'b0011, 4'b0011, 4'b0010, 16'd1, 16'd2, 16'd0, 16'd0);
    load_cycle(4'b0011, 4'b0001, 4'b0001, 16'd3, 16'd0, 16'd0, 16'd0);
    tick();
    check("t6_in_merge", 32'(ms_col_ena), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_ena", 32'(ms_col_ena), 32'd0);
    check("t6_async_out_vld", 32'(out_vld), 32'd0);
    check("t6_async_cnt", 32'(elem_cnt), 32'd0);
    out_rdy = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    push_exp(16'd7, 1'b1);
    do_start(4'b0001);
    load_cycle(4'b0001, 4'b0001, 4'b0001, 16'd7, 16'd0, 16'd0, 16'd0);
    wait_done(100, dcyc);
    check("t6_restart_cnt", 32'(elem_cnt), 32'd1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hams_merge_sort_ctrl.md
Name: hams_merge_sort_ctrl

Overview:
Sequences one merge job through hams_4to1_merge_sort. It loads up to 4 pre-sorted column streams into the sorter's column FIFOs. It holds col_ena low until every active column has delivered its last element, because the sorter would otherwise pop a head before its sibling column has arrived. It then enables the merge, drains the merged stream to a valid/ready consumer, counts elements and flags order violations or stalls.

Parameters:
FIFO_DEPTH, 2**10, total sorter depth; must match the sorter instance (FIFO_DEPTH/4 entries per column).
STALL_CYCLES, 64, consecutive MERGE cycles with no output before err_stall.
CNT_W, $clog2(FIFO_DEPTH)+1, element counter width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin job; sampled only in IDLE
col_mask  in  4  active columns; sampled with start
in_vld  in  4  per-column element valid
in_data  in  pair[4]  per-column element (key = .info)
in_last  in  4  qualifies in_vld: final element of that column
in_rdy  out  1  common accept for all columns
out_vld  out  1  merged element valid
out_data  out  pair  merged element
out_last  out  1  final merged element of job
out_rdy  in  1  consumer accept
ms_col_ena  out  4  to sorter col_ena
ms_col_vld  out  4  to sorter colDataVld
ms_col_data  out  pair[4]  to sorter colData
ms_fifo_pop  out  1  to sorter fifo_pop
ms_fifo_full  in  1  from sorter fifo_full
ms_fifo_empty  in  1  from sorter fifo_empty
ms_sort_data  in  pair  from sorter sort_data_o (show-ahead: valid whenever !empty)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on job completion
err_order  out  1  sticky; column key not strictly increasing
err_stall  out  1  sticky; merge stalled
elem_cnt  out  CNT_W  elements accepted in current/last job

Behaviour:
- Reset: state IDLE; all outputs 0, counters 0, masks 0, sticky errors cleared. Only rst_n clears errors.
- States: IDLE, LOAD, MERGE, DONE.
- IDLE: on start, latch col_mask into act, clear pend_last := col_mask and clear counters, then go to LOAD. A start with col_mask == 0 goes directly to DONE.
- LOAD:
  - in_rdy = !ms_fifo_full.
  - ms_col_vld[i] = in_vld[i] & act[i] & in_rdy. Inactive columns are ignored. ms_col_data passes through.
  - Each accepted element increments push_cnt (+1 per column, so up to +4 per cycle).
  - An accepted element with in_last clears pend_last[i].
  - When pend_last == 0 after the update, go to MERGE the next cycle.
  - Order check: prev_key[i] is held per column. An accepted element with key <= prev_key[i] (not the first of that column) sets err_order. Equal keys deadlock the sorter comparator, so equal is a violation. Data is still pushed.
- MERGE:
  - ms_col_ena = act; in_rdy = 0.
  - out_vld = !ms_fifo_empty; out_data = ms_sort_data; ms_fifo_pop = out_vld & out_rdy.
  - pop_cnt increments per pop. out_last = out_vld & (pop_cnt == push_cnt-1).
  - A pop with out_last goes to DONE.
  - Stall counter resets on any pop or while out_vld & !out_rdy (consumer backpressure is not a stall). Otherwise it increments.
  - Reaching STALL_CYCLES sets err_stall and goes to DONE. The FIFO contents are then undefined and recovery is by reset.
- DONE: done = 1 for exactly one cycle; ms_col_ena = 0; go to IDLE. elem_cnt holds push_cnt until the next start.
- ms_col_ena = 0 in every state except MERGE. ms_col_vld = 0 outside LOAD.
- Counters saturate at 2**CNT_W-1. push_cnt never exceeds FIFO_DEPTH because ms_fifo_full backpressures.
- A start outside IDLE is ignored. An in_vld outside LOAD is ignored (in_rdy = 0).

Decomposition:
- hams_pkg gets: typedef enum ms_ctrl_state_e {IDLE, LOAD, MERGE, DONE}; constant MS_NUM_COLS = 4. Reuse the existing pair typedef and NUM_ELEMENTS.
- One natural sub-module: hams_col_order_chk, a per-column prev-key register plus comparator, instantiated 4x.

Test Plan:
- mask 4'b1111, columns {1,5,9},{2,6},{3,7,11,12},{4} with last on final elements -> out keys 1,2,3,4,5,6,7,9,11,12; out_last on key 12; done one cycle later; elem_cnt = 10; no errors.
- mask 4'b0101, col0 {10,30}, col2 {20}, junk on col1/col3 -> out 10,20,30; junk never reaches ms_col_vld.
- col1 delivers last 20 cycles after the other columns -> ms_col_ena stays 0 until the cycle after col1's last, then the merge output is correctly ordered.
- out_rdy held low 200 cycles mid-merge -> no err_stall; out_data stable; merge resumes correctly.
- col0 {5,5} and col1 {5} -> err_order set in LOAD; the sorter deadlocks and err_stall is set after 64 idle cycles; done pulses; errors stay set until rst_n.
- rst_n asserted mid-MERGE -> all outputs 0 immediately (async); state IDLE; a new start is accepted after release.
